hazard_unit_mc: RTL and testbench

Parametrised successor to the 5-stage pipeline hazard unit. It provides EX- and D-stage forwarding, correct load-use and branch-operand stalls, and a multi-cycle multiply/divide (MDU) scoreboard. The scoreboard stalls the D stage while the HI/LO unit is busy. It sits beside the pipeline registers, and its stall/flush outputs drive the F/D enables and the E clear. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_unit_mc.sv | 142 ++++++++++++++
 tb/tb_hazard_unit_mc.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: pipeline hazard unit with EX/D forwarding, load-use and
// branch-operand stalls, a multi-cycle MDU scoreboard and a saturating
// stall-cycle counter for performance measurement.
module hazard_unit_mc #(
  parameter int AW      = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic [AW-1:0] rs_e,
  input  logic [AW-1:0] rt_e,
  input  logic [AW-1:0] writereg_e,
  input  logic [AW-1:0] writereg_m,
  input  logic [AW-1:0] writereg_w,
  input  logic          regwrite_e,
  input  logic          regwrite_m,
  input  logic          regwrite_w,
  input  logic          memtoreg_e,
  input  logic          memtoreg_m,
  input  logic          branch_d,
  input  logic          mdu_start_e,
  input  logic          mdu_div_e,
  input  logic          mdu_use_d,
  input  logic          stat_clr,
  output logic [1:0]    forward_ae,
  output logic [1:0]    forward_be,
  output logic          forward_ad,
  output logic          forward_bd,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_e,
  output logic          mdu_busy,
  output logic          mdu_done,
  output logic [CW-1:0] stall_count
);

  localparam logic [7:0] MUL_CNT = 8'(MUL_LAT);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [7:0]    mdu_cnt_q, mdu_cnt_d;
  logic          mdu_done_q, mdu_done_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]    start_lat;
  logic          lwstall;
  logic          brstall;
  logic          mdustall;
  logic          stall;

  // EX operand forwarding: the younger M result wins over W; r0 never forwards
  always_comb begin
    forward_ae = 2'b00;
    forward_be = 2'b00;
    if (regwrite_m && (rs_e != '0) && (rs_e == writereg_m))      forward_ae = 2'b10;
    else if (regwrite_w && (rs_e != '0) && (rs_e == writereg_w)) forward_ae = 2'b01;
    if (regwrite_m && (rt_e != '0) && (rt_e == writereg_m))      forward_be = 2'b10;
    else if (regwrite_w && (rt_e != '0) && (rt_e == writereg_w)) forward_be = 2'b01;
  end

  // D-stage branch comparator bypass from the M result
  always_comb begin
    forward_ad = (rs_d != '0) && (rs_d == writereg_m) && regwrite_m;
    forward_bd = (rt_d != '0) && (rt_d == writereg_m) && regwrite_m;
  end

  // Stall sources: load-use, branch operand not yet available, MDU still busy
  always_comb begin
    lwstall  = memtoreg_e && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));
    brstall  = branch_d &&
               ((regwrite_e && (writereg_e != '0) &&
                 ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
                (memtoreg_m && (writereg_m != '0) &&
                 ((writereg_m == rs_d) || (writereg_m == rt_d))));
    mdustall = mdu_use_d && mdu_busy;
    stall    = lwstall || brstall || mdustall;
    stall_f  = stall;
    stall_d  = stall;
    flush_e  = stall;
  end

  assign mdu_busy    = (mdu_cnt_q != 8'd0);
  assign mdu_done    = mdu_done_q;
  assign stall_count = stall_cnt_q;
  assign start_lat   = mdu_div_e ? DIV_CNT : MUL_CNT;

  // MDU scoreboard: load latency on start, count down, pulse done on 1->0;
  // a start landing on the final busy cycle reloads while done still pulses
  always_comb begin
    state_d    = state_q;
    mdu_cnt_d  = mdu_cnt_q;
    mdu_done_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (mdu_start_e) begin
        mdu_cnt_d = start_lat;
        state_d   = ST_BUSY;
      end
    end else begin
      mdu_cnt_d = mdu_cnt_q - 8'd1;
      if (mdu_cnt_q <= 8'd1) begin
        mdu_done_d = 1'b1;
        state_d    = ST_IDLE;
        mdu_cnt_d  = 8'd0;
        if (mdu_start_e) begin
          mdu_cnt_d = start_lat;
          state_d   = ST_BUSY;
        end
      end
    end
  end

  // Saturating stall-cycle counter; clear has priority over counting
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr)
      stall_cnt_d = '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + {{(CW-1){1'b0}}, 1'b1};
  end

  // State registers; reset drops the scoreboard to idle without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mdu_cnt_q   <= 8'd0;
      mdu_done_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      mdu_done_q  <= mdu_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: self-checking bench for hazard_unit_mc. A table of
// combinational hazard cases, hand-written MDU/counter sequences and a random
// phase, all checked against a behavioural model kept in this file.
module tb_hazard_unit_mc;

  localparam int AW      = 5;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic          regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
  logic          branch_d, mdu_start_e, mdu_div_e, mdu_use_d, stat_clr;
  logic [1:0]    forward_ae, forward_be;
  logic          forward_ad, forward_bd, stall_f, stall_d, flush_e;
  logic          mdu_busy, mdu_done;
  logic [CW-1:0] stall_count;

  int n_cmp;
  int n_fail;

  // Model state: remaining MDU busy cycles, pending done pulse, stall cycles
  int m_rem;
  bit m_done;
  int m_cnt;

  typedef struct packed {
    logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic          rw_e, rw_m, rw_w, mtr_e, mtr_m, br_d;
    logic [1:0]    fae, fbe;
    logic          fad, fbd, stall;
  } vec_t;

  vec_t vecs[14];

  hazard_unit_mc #(.AW(AW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m), .branch_d(branch_d),
    .mdu_start_e(mdu_start_e), .mdu_div_e(mdu_div_e), .mdu_use_d(mdu_use_d),
    .stat_clr(stat_clr),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .forward_ad(forward_ad), .forward_bd(forward_bd),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_count(stall_count)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it, report it if it differs
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Forwarding select from the rules: M beats W, register 0 never forwards
  function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
    if (src != 0 && regwrite_m && src == writereg_m) return 2'b10;
    if (src != 0 && regwrite_w && src == writereg_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit model_stall();
    bit lw, br, md;
    lw = memtoreg_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
    br = branch_d &&
         ((regwrite_e && writereg_e != 0 && (writereg_e == rs_d || writereg_e == rt_d)) ||
          (memtoreg_m && writereg_m != 0 && (writereg_m == rs_d || writereg_m == rt_d)));
    md = mdu_use_d && (m_rem > 0);
    return lw || br || md;
  endfunction

  // Compare every DUT output against the model for the current inputs
  task automatic checkModel();
    bit s;
    s = model_stall();
    checkOutput("forward_ae", 32'(forward_ae), 32'(model_fwd(rs_e)));
    checkOutput("forward_be", 32'(forward_be), 32'(model_fwd(rt_e)));
    checkOutput("forward_ad", 32'(forward_ad), 32'(rs_d != 0 && rs_d == writereg_m && regwrite_m));
    checkOutput("forward_bd", 32'(forward_bd), 32'(rt_d != 0 && rt_d == writereg_m && regwrite_m));
    checkOutput("stall_f", 32'(stall_f), 32'(s));
    checkOutput("stall_d", 32'(stall_d), 32'(s));
    checkOutput("flush_e", 32'(flush_e), 32'(s));
    checkOutput("mdu_busy", 32'(mdu_busy), 32'(m_rem > 0));
    checkOutput("mdu_done", 32'(mdu_done), 32'(m_done));
    checkOutput("stall_count", 32'(stall_count), 32'(m_cnt));
  endtask

  task automatic resetModel();
    m_rem  = 0;
    m_done = 0;
    m_cnt  = 0;
  endtask

  // Advance the model by one clock edge using the inputs held this cycle
  task automatic updateModel();
    bit s;
    if (!rst_n) begin
      resetModel();
      return;
    end
    s = model_stall();
    if (stat_clr) m_cnt = 0;
    else if (s && m_cnt < CNT_MAX) m_cnt++;
    m_done = (m_rem == 1);
    if (mdu_start_e && m_rem <= 1) m_rem = mdu_div_e ? DIV_LAT : MUL_LAT;
    else if (m_rem > 0) m_rem--;
  endtask

  task automatic clearInputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    writereg_e = '0; writereg_m = '0; writereg_w = '0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
    memtoreg_e = 0; memtoreg_m = 0; branch_d = 0;
    mdu_start_e = 0; mdu_div_e = 0; mdu_use_d = 0; stat_clr = 0;
  endtask

  // Drive one table vector (no MDU activity) and let it settle
  task automatic applyStimulus(input vec_t v);
    clearInputs();
    rs_d = v.rs_d; rt_d = v.rt_d; rs_e = v.rs_e; rt_e = v.rt_e;
    writereg_e = v.wr_e; writereg_m = v.wr_m; writereg_w = v.wr_w;
    regwrite_e = v.rw_e; regwrite_m = v.rw_m; regwrite_w = v.rw_w;
    memtoreg_e = v.mtr_e; memtoreg_m = v.mtr_m; branch_d = v.br_d;
    #1;
  endtask

  // Settle inputs driven at the falling edge, check against the model
  task automatic settle();
    #1;
    checkModel();
  endtask

  // Take the rising edge (model follows) and return at the next falling edge
  task automatic advance();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  // Hazard cases with hand-derived expected values
  task automatic fillTable();
    for (int i = 0; i < 14; i++) vecs[i] = '0;
    vecs[0].rs_e = 3; vecs[0].wr_m = 3; vecs[0].wr_w = 3; vecs[0].rw_m = 1; vecs[0].rw_w = 1; vecs[0].fae = 2'b10;
    vecs[1].rs_e = 3; vecs[1].wr_m = 3; vecs[1].wr_w = 3; vecs[1].rw_w = 1; vecs[1].fae = 2'b01;
    vecs[2].wr_m = 3; vecs[2].wr_w = 3; vecs[2].rw_w = 1; vecs[2].rw_m = 1;
    vecs[3].rt_e = 5; vecs[3].wr_m = 5; vecs[3].wr_w = 5; vecs[3].rw_w = 1; vecs[3].fbe = 2'b01;
    vecs[4].mtr_e = 1; vecs[4].rt_e = 7; vecs[4].rt_d = 7; vecs[4].stall = 1;
    vecs[5].mtr_e = 1;
    vecs[6].mtr_e = 1; vecs[6].rt_e = 4; vecs[6].rs_d = 4; vecs[6].stall = 1;
    vecs[7].br_d = 1; vecs[7].rs_d = 9; vecs[7].rw_e = 1; vecs[7].wr_e = 9; vecs[7].stall = 1;
    vecs[8].br_d = 1; vecs[8].rs_d = 9; vecs[8].rw_m = 1; vecs[8].wr_m = 9; vecs[8].fad = 1;
    vecs[9].br_d = 1; vecs[9].rt_d = 6; vecs[9].wr_m = 6; vecs[9].mtr_m = 1; vecs[9].rw_m = 1; vecs[9].fbd = 1; vecs[9].stall = 1;
    vecs[10].br_d = 1; vecs[10].rw_e = 1;
    vecs[11].rw_e = 1; vecs[11].wr_e = 9; vecs[11].rs_d = 9;
    vecs[12].rs_d = 9; vecs[12].wr_m = 9;
    vecs[13].rs_e = 8; vecs[13].rt_e = 8; vecs[13].wr_m = 8; vecs[13].rw_m = 1; vecs[13].wr_w = 8; vecs[13].rw_w = 1;
    vecs[13].fae = 2'b10; vecs[13].fbe = 2'b10;
  endtask

  // Main test sequence
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    resetModel();
    clearInputs();
    rst_n = 1'b0;
    fillTable();

    // Reset state
    @(negedge clk);
    #1;
    checkOutput("reset mdu_busy", 32'(mdu_busy), 32'd0);
    checkOutput("reset mdu_done", 32'(mdu_done), 32'd0);
    checkOutput("reset stall_count", 32'(stall_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven combinational hazard cases
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkModel();
      checkOutput($sformatf("vec%0d forward_ae", i), 32'(forward_ae), 32'(vecs[i].fae));
      checkOutput($sformatf("vec%0d forward_be", i), 32'(forward_be), 32'(vecs[i].fbe));
      checkOutput($sformatf("vec%0d forward_ad", i), 32'(forward_ad), 32'(vecs[i].fad));
      checkOutput($sformatf("vec%0d forward_bd", i), 32'(forward_bd), 32'(vecs[i].fbd));
      checkOutput($sformatf("vec%0d stall", i), 32'({stall_f, stall_d, flush_e}), 32'({3{vecs[i].stall}}));
      advance();
    end

    // Multiply: busy for MUL_LAT cycles with D stalled, then done pulse
    clearInputs();
    mdu_start_e = 1;
    settle();
    advance();
    for (int c = 0; c < MUL_LAT; c++) begin
      clearInputs();
      mdu_use_d = 1;
      settle();
      checkOutput($sformatf("mul busy c%0d", c), 32'(mdu_busy), 32'd1);
      checkOutput($sformatf("mul stall c%0d", c), 32'({stall_f, stall_d, flush_e}), 32'b111);
      checkOutput($sformatf("mul done c%0d", c), 32'(mdu_done), 32'd0);
      advance();
    end
    clearInputs();
    mdu_use_d = 1;
    settle();
    checkOutput("mul done pulse", 32'(mdu_done), 32'd1);
    checkOutput("mul busy after", 32'(mdu_busy), 32'd0);
    checkOutput("mul stall after", 32'(stall_d), 32'd0);
    advance();
    clearInputs();
    settle();
    checkOutput("mul done one cycle", 32'(mdu_done), 32'd0);
    advance();

    // Start on the last busy cycle: reload wins, done still pulses
    clearInputs();
    mdu_start_e = 1;
    settle();
    advance();
    for (int c = 0; c < MUL_LAT; c++) begin
      clearInputs();
      mdu_start_e = (c == MUL_LAT - 1);
      settle();
      advance();
    end
    clearInputs();
    settle();
    checkOutput("back-to-back done", 32'(mdu_done), 32'd1);
    checkOutput("back-to-back busy", 32'(mdu_busy), 32'd1);
    for (int c = 0; c < MUL_LAT + 2; c++) begin
      clearInputs();
      settle();
      advance();
    end

    // Divide interrupted by reset at cycle 10: busy drops, no done pulse
    clearInputs();
    mdu_start_e = 1;
    mdu_div_e = 1;
    settle();
    advance();
    for (int c = 1; c < 10; c++) begin
      clearInputs();
      settle();
      checkOutput($sformatf("div busy c%0d", c), 32'(mdu_busy), 32'd1);
      advance();
    end
    clearInputs();
    settle();
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("div reset busy", 32'(mdu_busy), 32'd0);
    checkOutput("div reset done", 32'(mdu_done), 32'd0);
    advance();
    rst_n = 1'b1;
    for (int c = 0; c < DIV_LAT + 4; c++) begin
      clearInputs();
      settle();
      checkOutput($sformatf("post-reset done c%0d", c), 32'(mdu_done), 32'd0);
      advance();
    end

    // Stall counter: saturate at all-ones, clear has priority over a stall
    clearInputs();
    stat_clr = 1;
    settle();
    advance();
    for (int c = 0; c < 20; c++) begin
      clearInputs();
      memtoreg_e = 1; rt_e = 7; rt_d = 7;
      settle();
      advance();
    end
    clearInputs();
    memtoreg_e = 1; rt_e = 7; rt_d = 7;
    settle();
    checkOutput("count saturated", 32'(stall_count), 32'(CNT_MAX));
    stat_clr = 1;
    advance();
    clearInputs();
    settle();
    checkOutput("count cleared", 32'(stall_count), 32'd0);
    advance();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rs_d = AW'($urandom_range(0, 3)); rt_d = AW'($urandom_range(0, 3));
      rs_e = AW'($urandom_range(0, 3)); rt_e = AW'($urandom_range(0, 3));
      writereg_e = AW'($urandom_range(0, 3));
      writereg_m = AW'($urandom_range(0, 3));
      writereg_w = AW'($urandom_range(0, 3));
      regwrite_e = 1'($urandom_range(0, 1)); regwrite_m = 1'($urandom_range(0, 1));
      regwrite_w = 1'($urandom_range(0, 1)); memtoreg_e = 1'($urandom_range(0, 1));
      memtoreg_m = 1'($urandom_range(0, 1)); branch_d = 1'($urandom_range(0, 1));
      mdu_start_e = ($urandom_range(0, 7) == 0);
      mdu_div_e = ($urandom_range(0, 3) == 0);
      mdu_use_d = 1'($urandom_range(0, 1));
      stat_clr = ($urandom_range(0, 24) == 0);
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
